// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator and its LFSR.
package bounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  localparam int              LFSR_WIDTH     = 16;
  localparam logic [15:0]     LFSR_MASK      = 16'hB400;
  localparam logic [7:0]      TOGGLE_CNT_MAX = 8'hFF;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr16
  import bounce_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [LFSR_WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= (seed == '0) ? LFSR_WIDTH'(1) : seed;
    end else begin
      out <= lfsr_step(out);
    end
  end

endmodule

// File: rtl/bounce_emulator.sv
// Turns a clean press level into a bouncing button waveform with LFSR-driven
// spurious toggles inside a fixed-length window after every press change.
module bounce_emulator
  import bounce_pkg::*;
#(
  parameter int          BOUNCE_CYCLES = 4096,
  parameter int          TOGGLE_DIV    = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic       enable_bounce,
  output logic       button,
  output logic       settled,
  output logic [7:0] toggle_count
);

  localparam int WIN_W = $clog2(BOUNCE_CYCLES);
  localparam int GAP_W = ($clog2(TOGGLE_DIV) > 1) ? $clog2(TOGGLE_DIV) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TOGGLE_DIV - 1);

  state_t                  state_reg;
  logic                    target_reg;
  logic                    button_reg;
  logic                    settled_reg;
  logic [7:0]              toggle_count_reg;
  logic [WIN_W-1:0]        window_cnt_reg;
  logic [GAP_W-1:0]        gap_cnt_reg;
  logic [LFSR_WIDTH-1:0]   lfsr_value;
  logic                    lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .out   (lfsr_value)
  );

  // Upper LFSR bits are kept visible for observation but do not steer the bounce.
  assign lfsr_unused = ^lfsr_value[LFSR_WIDTH-1:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= STABLE;
      target_reg       <= 1'b0;
      button_reg       <= 1'b0;
      settled_reg      <= 1'b1;
      toggle_count_reg <= 8'd0;
      window_cnt_reg   <= '0;
      gap_cnt_reg      <= '0;
    end else begin
      case (state_reg)
        STABLE: begin
          button_reg  <= target_reg;
          settled_reg <= 1'b1;
          if (press != target_reg) begin
            target_reg <= press;
            button_reg <= press;
            if (enable_bounce) begin
              settled_reg      <= 1'b0;
              window_cnt_reg   <= '0;
              gap_cnt_reg      <= '0;
              toggle_count_reg <= 8'd0;
              state_reg        <= BOUNCE;
            end
          end
        end

        BOUNCE: begin
          if (!enable_bounce) begin
            button_reg  <= target_reg;
            settled_reg <= 1'b1;
            state_reg   <= STABLE;
          end else if (press != target_reg) begin
            // A new press change restarts the whole window from first contact.
            target_reg       <= press;
            button_reg       <= press;
            window_cnt_reg   <= '0;
            gap_cnt_reg      <= '0;
            toggle_count_reg <= 8'd0;
          end else if (window_cnt_reg == WIN_LAST) begin
            button_reg  <= target_reg;
            settled_reg <= 1'b1;
            state_reg   <= STABLE;
          end else begin
            window_cnt_reg <= window_cnt_reg + WIN_W'(1);
            if (gap_cnt_reg == GAP_LAST) begin
              gap_cnt_reg <= '0;
              if (lfsr_value[0]) begin
                button_reg <= ~button_reg;
                if (toggle_count_reg != TOGGLE_CNT_MAX) begin
                  toggle_count_reg <= toggle_count_reg + 8'd1;
                end
              end
            end else begin
              gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
          end
        end

        default: begin
          state_reg <= STABLE;
        end
      endcase
    end
  end

  assign button       = button_reg;
  assign settled      = settled_reg;
  assign toggle_count = toggle_count_reg;

endmodule

// File: tb/tb_bounce_emulator.sv
// Cycle-level scoreboard bench for bounce_emulator with a short window (16) and gap (4).
module tb_bounce_emulator;

  localparam int          BC   = 16;
  localparam int          TD   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       press = 1'b0;
  logic       enable_bounce = 1'b0;
  logic       button, settled;
  logic [7:0] toggle_count;
  logic       button0, settled0;
  logic [7:0] toggle_count0;

  always #5 clk = ~clk;

  bounce_emulator #(.BOUNCE_CYCLES(BC), .TOGGLE_DIV(TD), .LFSR_SEED(SEED)) dut (
    .clk           (clk),
    .reset         (reset),
    .press         (press),
    .enable_bounce (enable_bounce),
    .button        (button),
    .settled       (settled),
    .toggle_count  (toggle_count)
  );

  bounce_emulator #(.BOUNCE_CYCLES(BC), .TOGGLE_DIV(TD), .LFSR_SEED(16'h0000)) dut0 (
    .clk           (clk),
    .reset         (reset),
    .press         (press),
    .enable_bounce (enable_bounce),
    .button        (button0),
    .settled       (settled0),
    .toggle_count  (toggle_count0)
  );

  typedef struct packed {
    logic       button;
    logic       settled;
    logic [7:0] tc;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // Reference model state
  bit          m_bouncing;
  bit          m_target, m_button, m_settled;
  int          m_tc, m_phase;
  logic [15:0] m_lfsr;

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    logic [15:0] n;
    n = {1'b0, l[15:1]};
    if (l[0]) begin
      n[15] = ~n[15];
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  task automatic model_edge();
    bit lsb;
    if (reset) begin
      m_bouncing = 0; m_target = 0; m_button = 0; m_settled = 1;
      m_tc = 0; m_phase = 0; m_lfsr = SEED;
    end else begin
      lsb    = m_lfsr[0];
      m_lfsr = ref_lfsr(m_lfsr);
      if (!m_bouncing) begin
        m_settled = 1;
        if (press != m_target) begin
          m_target = press;
          m_button = press;
          if (enable_bounce) begin
            m_bouncing = 1; m_settled = 0; m_phase = 0; m_tc = 0;
          end
        end
      end else if (!enable_bounce) begin
        m_button = m_target; m_settled = 1; m_bouncing = 0;
      end else if (press != m_target) begin
        m_target = press; m_button = press; m_phase = 0; m_tc = 0;
      end else if (m_phase == BC - 1) begin
        m_button = m_target; m_settled = 1; m_bouncing = 0;
      end else begin
        if ((m_phase % TD) == TD - 1 && lsb) begin
          m_button = ~m_button;
          if (m_tc < 255) m_tc++;
        end
        m_phase++;
      end
    end
  endtask

  // One clock: predict, push, advance, pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    e.button  = m_button;
    e.settled = m_settled;
    e.tc      = 8'(m_tc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_value("button", int'(button), int'(e.button));
    check_value("settled", int'(settled), int'(e.settled));
    check_value("toggle_count", int'(toggle_count), int'(e.tc));
  endtask

  task automatic check_reset_state();
    check_value("lfsr_seed", int'(dut.lfsr_value), int'(SEED));
    check_value("lfsr_seed0", int'(dut0.lfsr_value), 1);
    check_value("button0", int'(button0), 0);
    check_value("settled0", int'(settled0), 1);
    check_value("toggle_count0", int'(toggle_count0), 0);
  endtask

  initial begin
    int trans;
    bit prev;

    phase = "reset";
    reset = 1'b1; press = 1'b0; enable_bounce = 1'b0;
    step();
    step();
    check_reset_state();
    reset = 1'b0;
    step();
    check_value("lfsr_model", int'(dut.lfsr_value), int'(m_lfsr));

    phase = "passthrough";
    press = 1'b1;
    step();
    step();
    press = 1'b0;
    step();
    step();

    // Several full bounce windows, counting spurious transitions seen on button.
    enable_bounce = 1'b1;
    for (int w = 0; w < 4; w++) begin
      phase = $sformatf("window%0d", w);
      press = ~press;
      step();
      prev  = button;
      trans = 0;
      for (int i = 0; i < BC + 3; i++) begin
        step();
        if (!settled && button != prev) trans++;
        prev = button;
      end
      check_value("tc_vs_transitions", int'(toggle_count), trans);
      check_value("lfsr_model", int'(dut.lfsr_value), int'(m_lfsr));
    end

    phase = "repress";
    press = ~press;
    for (int i = 0; i < 8; i++) step();
    press = ~press;
    step();
    check_value("repress_button", int'(button), int'(press));
    for (int i = 0; i < BC + 2; i++) step();

    phase = "enable_drop";
    press = ~press;
    for (int i = 0; i < 9; i++) step();
    enable_bounce = 1'b0;
    step();
    check_value("drop_settled", int'(settled), 1);
    check_value("drop_button", int'(button), int'(press));
    for (int i = 0; i < 4; i++) step();

    phase = "reset_mid_bounce";
    enable_bounce = 1'b1;
    press = ~press;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    check_reset_state();
    reset = 1'b0;
    press = 1'b0;
    step();

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) press = ~press;
      if ($urandom_range(0, 39) == 0) enable_bounce = ~enable_bounce;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
- Synthesizable mechanical-switch emulator: converts a clean press level into a bouncing button waveform.
- Drives debouncer inputs on-board and in benches without a physical switch.
- Sits between a test controller (or slide switch) and the button input of any debounce/edge-detect path.
- Bounce timing is pseudo-random, from an internal 16-bit LFSR.

Parameters:
- BOUNCE_CYCLES, 4096: length of the bounce window in clk cycles after each press change; legal range >= 2.
- TOGGLE_DIV, 64: spacing of toggle opportunities inside the window, in cycles; legal range >= 1.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- press  input  1  clean intended switch level
- enable_bounce  input  1  1 = emulate bounce; 0 = pass press through with 1-cycle latency
- button  output  1  emulated raw switch output (registered)
- settled  output  1  1 = button equals target and no bounce window is active (registered)
- toggle_count  output  8  number of spurious toggles in the current or most recent window, saturating at 255

Behaviour:
- Reset, on posedge clk with reset=1, overrides all other inputs:
  - state=STABLE, target=0, button=0, settled=1, toggle_count=0
  - window_cnt=0, gap_cnt=0, lfsr=LFSR_SEED (or 1 if the seed is 0)
- LFSR:
  - Galois form, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Advances every non-reset cycle in every state.
  - Only lfsr[0] is consumed.
- Counter widths:
  - window_cnt is $clog2(BOUNCE_CYCLES) bits.
  - gap_cnt is max(1,$clog2(TOGGLE_DIV)) bits.
  - Neither counter ever wraps; both are reloaded explicitly.
- STABLE, press==target: hold button=target, settled=1.
- STABLE, press!=target, enable_bounce=0:
  - target<=press, button<=press; remain STABLE, settled stays 1.
  - Latency is 1 cycle.
- STABLE, press!=target, enable_bounce=1 (first contact), on the next edge:
  - target<=press, button<=press, settled<=0.
  - window_cnt<=0, gap_cnt<=0, toggle_count<=0.
  - state<=BOUNCE.
- BOUNCE, each cycle:
  - window_cnt increments.
  - gap_cnt increments; when gap_cnt==TOGGLE_DIV-1, gap_cnt<=0.
  - At that toggle opportunity, if lfsr[0]==1: button<=~button and toggle_count increments (saturating).
- BOUNCE exit, when window_cnt==BOUNCE_CYCLES-1:
  - button<=target, settled<=1, state<=STABLE.
  - Exit takes priority over a toggle opportunity in the same cycle.
  - Total BOUNCE occupancy is exactly BOUNCE_CYCLES cycles.
- BOUNCE, press!=target (re-press mid-window):
  - target<=press, button<=press.
  - window_cnt<=0, gap_cnt<=0, toggle_count<=0.
  - Remain BOUNCE; the window restarts.
  - Takes priority over exit and over toggles.
- BOUNCE, enable_bounce falls to 0:
  - Next edge: button<=target, settled<=1, state<=STABLE.
  - toggle_count holds its value.
- Reset during BOUNCE: immediate return to reset values; no final toggle is emitted.
- Invariant: in STABLE, button==target always.

Decomposition:
- Package bounce_pkg:
  - state enum {STABLE, BOUNCE}
  - LFSR_MASK=16'hB400
  - LFSR_WIDTH=16
  - TOGGLE_CNT_MAX=8'hFF
- One sub-module, lfsr16:
  - Ports: clk, reset, seed, out[15:0].
  - Free-running Galois LFSR; substitutes seed 0 with 1.
  - Reusable by other stimulus blocks.
- The top level holds the FSM, window and gap counters, and toggle_count.

Test Plan:
- Reset with BOUNCE_CYCLES=16, TOGGLE_DIV=4, press=0 -> button=0, settled=1, toggle_count=0; lfsr=16'hACE1 on the first post-reset cycle.
- enable_bounce=0, press 0->1 at edge N -> button=1 at N+1, settled stays 1, toggle_count=0.
- enable_bounce=1, press 0->1 at edge N:
  - button=1 and settled=0 at N+1.
  - Toggles only on cycles where gap_cnt==3 and lfsr[0]==1 (check against a reference LFSR model).
  - button=1 and settled=1 at N+17; toggle_count equals the number of observed button transitions.
- Re-press mid-window: press 0->1, then 1->0 eight cycles later -> button=0 on the next edge, toggle_count=0, window restarts, settled=1 exactly 16 cycles after the second change.
- enable_bounce dropped mid-window -> next edge button=target and settled=1; toggle_count frozen at its value.
- Reset asserted mid-BOUNCE -> next edge button=0, settled=1, toggle_count=0, lfsr=seed; with LFSR_SEED=0, lfsr=16'h0001.
